// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: multi-cycle data-memory access sequencer behind the MEM stage.
// Takes one load/store from the MEM stage, runs it on a req/ack bus and stalls the
// pipeline until it completes. A flush during a bus transaction is absorbed without
// a done pulse.
// Optional feature macro: BUS_TIMEOUT_EN (bus timeout counter and sticky err_o).
module mem_bus_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_req_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   input  logic [3:0]  mem_sel_i,
   input  logic        flush_i,
   output logic [31:0] mem_data_o,
   output logic        mem_done_o,
   output logic        stallreq_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_data_o,
   output logic [3:0]  bus_sel_o,
   input  logic [31:0] bus_data_i,
   input  logic        bus_ack_i,
   output logic        err_o
);

   // The timeout counter must be able to represent TIMEOUT_CYCLES - 1.
   if (TIMEOUT_CYCLES == 0 || (CNT_W < 32 && TIMEOUT_CYCLES >= (32'd1 << CNT_W)))
   begin : g_bad_params
      $error("mem_bus_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StAbort, StDone} state_e;

   state_e state_q, state_d;

   logic accept;       // new request latched onto the bus
   logic bus_release;  // bus transaction finished (ack or timeout)
   logic capture;      // load data taken from the bus
   logic clear_data;   // timed-out load returns zero
   logic done_d;       // next value of mem_done_o
   logic timeout;      // limit reached this cycle with no ack

`ifdef BUS_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_q;

   assign timeout = (state_q == StBusy || state_q == StAbort) && !bus_ack_i &&
                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count unacknowledged bus cycles; err_o is sticky until the next accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_o <= 1'b0;
      end else if (accept) begin
         cnt_q <= '0;
         err_o <= 1'b0;
      end else begin
         if ((state_q == StBusy || state_q == StAbort) && !bus_ack_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
         if (timeout) begin
            err_o <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

   // Next-state and per-cycle actions; ack always wins over timeout.
   always_comb begin
      state_d     = state_q;
      accept      = 1'b0;
      bus_release = 1'b0;
      capture     = 1'b0;
      clear_data  = 1'b0;
      done_d      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mem_req_i && !flush_i) begin
               accept  = 1'b1;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (bus_ack_i) begin
               bus_release = 1'b1;
               if (flush_i) begin
                  // Instruction discarded: drop the data, no done pulse.
                  state_d = StIdle;
               end else begin
                  capture = !bus_we_o;
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end else if (timeout) begin
               bus_release = 1'b1;
               if (flush_i) begin
                  state_d = StIdle;
               end else begin
                  clear_data = !bus_we_o;
                  done_d     = 1'b1;
                  state_d    = StDone;
               end
            end else if (flush_i) begin
               // Bus transaction cannot be withdrawn; wait for its ack.
               state_d = StAbort;
            end
         end
         StAbort: begin
            if (bus_ack_i || timeout) begin
               bus_release = 1'b1;
               state_d     = StIdle;
            end
         end
         StDone: begin
            // Any mem_req_i here belongs to the completing instruction.
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Stall while a request is being accepted, on the bus, or aborting under a new request.
   always_comb begin
      stallreq_o = ((state_q == StIdle) && mem_req_i && !flush_i) ||
                   (state_q == StBusy) ||
                   ((state_q == StAbort) && mem_req_i);
   end

   // State register, bus request/attribute registers and load result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         mem_data_o <= '0;
         mem_done_o <= 1'b0;
         bus_req_o  <= 1'b0;
         bus_we_o   <= 1'b0;
         bus_addr_o <= '0;
         bus_data_o <= '0;
         bus_sel_o  <= '0;
      end else begin
         state_q    <= state_d;
         mem_done_o <= done_d;
         if (accept) begin
            bus_req_o  <= 1'b1;
            bus_we_o   <= mem_we_i;
            bus_addr_o <= mem_addr_i;
            bus_data_o <= mem_data_i;
            bus_sel_o  <= mem_sel_i;
         end
         if (bus_release) begin
            bus_req_o <= 1'b0;
         end
         if (capture) begin
            mem_data_o <= bus_data_i;
         end else if (clear_data) begin
            mem_data_o <= '0;
         end
      end
   end

endmodule
